tt_sweep_ctrl: RTL and testbench
================================

# tt_sweep_ctrl

- Sequencer that exercises one 3-input combinational logic gate, such as the 0x9A Wolfram-coded gate.
- It drives the gate's in1/in2/in3 through all eight input combinations and waits a programmable settle time for each.
- It samples the gate output and compares the captured truth table against an expected 8-bit code.
- It sits between the characterization host and the gate instance, and is the only driver of the gate inputs.

## Interface
Parameters:
- EXPECTED, 8'h9A, expected truth table, MSB-first: bit (7-k) is the required output for combination k = {in1,in2,in3}.
- SETTLE_CYCLES, 4, cycles the inputs are held before each sample; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a sweep; sampled only in IDLE.
- dut_out, input, 1, output of the gate under control.
- in1, output, 1, gate input MSB.
- in2, output, 1, gate input middle bit.
- in3, output, 1, gate input LSB.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse when a sweep completes.
- pass, output, 1, high when captured == EXPECTED (and no instability, see Configuration).
- captured, output, 8, measured truth table, MSB-first.
- mismatch, output, 8, captured XOR EXPECTED.
- unstable, output, 8, per-combination instability flags; constant 0 when the macro is absent.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - in1..in3 = 000, busy = 0.
  - start = 1 → SETTLE with k = 0, settle counter = 0, and captured, mismatch, pass and unstable all cleared.
- SETTLE:
  - {in1,in2,in3} = k; the counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE → SAMPLE.
- SAMPLE:
  - Inputs are still k; captured[7-k] <= dut_out.
  - If k == 7 → DONE; otherwise k+1 and → SETTLE.
- DONE:
  - Lasts one cycle; done = 1, busy = 0, inputs = 000.
  - mismatch <= captured XOR EXPECTED; pass <= (mismatch == 0) and (unstable == 0).
  - Then → IDLE.
- Results are held from DONE until the next accepted start.
- start while busy or in DONE: ignored, not queued.
- rst (any state, including mid-sweep):
  - Takes effect next edge; → IDLE.
  - All outputs 0, k = 0, counter = 0.
  - No done pulse for the aborted sweep.
- Reset values: in1 = in2 = in3 = 0, busy = 0, done = 0, pass = 0, captured = 8'h00, mismatch = 8'h00, unstable = 8'h00.
- Counter arithmetic: saturating compare against SETTLE_CYCLES; no wrap within a combination. k wraps never (terminates at 7).

## Timing
- Cycle 0 is the cycle in which IDLE samples start = 1.
- busy is high in cycles 1 .. 8*(SETTLE_CYCLES+1).
- Combination k is driven in cycles 1 + k*(SETTLE_CYCLES+1) through (k+1)*(SETTLE_CYCLES+1); the last of these is its SAMPLE cycle.
- done is high in exactly cycle 8*(SETTLE_CYCLES+1)+1 (cycle 41 at the default).
- pass, mismatch and final captured are valid from that same cycle.
- The earliest next start is accepted in cycle 8*(SETTLE_CYCLES+1)+2.
- Input changes are registered outputs: no combinational path from start or dut_out to any output.

## Configuration
- Macro: TT_SWEEP_STABILITY_EN.
- Defined:
  - dut_out is also registered on the final SETTLE cycle of each combination.
  - If that value differs from the SAMPLE-cycle value, unstable[7-k] <= 1.
  - pass requires unstable == 0.
- Undefined:
  - The stability register and compare are omitted; unstable is tied to 8'h00.
  - pass depends only on mismatch.

## Test plan
- Ideal 0x9A gate model, SETTLE_CYCLES = 4, start pulse → busy cycles 1–40, done in cycle 41, captured = 8'h9A, mismatch = 8'h00, pass = 1.
- Stuck-at-1 gate → captured = 8'hFF, mismatch = 8'h65, pass = 0; inputs step 000..111 in order, each held 5 cycles.
- Gate model with 2-cycle output lag:
  - SETTLE_CYCLES = 1 → pass = 0 with nonzero mismatch.
  - SETTLE_CYCLES = 4 → captured = 8'h9A, pass = 1.
- start re-pulsed at cycle 10 and held high through DONE → single done at cycle 41, no second sweep until start is sampled in IDLE.
- rst at cycle 15 → cycle 16 shows busy = 0, inputs 000, captured = 8'h00, pass = 0, and no done pulse; a fresh start then completes normally.
- TT_SWEEP_STABILITY_EN defined, gate output toggling each cycle during combination 3 → unstable = 8'h10, pass = 0; with the macro undefined, unstable = 8'h00.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// Sweep sequencer for one 3-input gate: steps {in1,in2,in3} through 0..7, captures the truth table, compares to EXPECTED.
// Optional macro TT_SWEEP_STABILITY_EN adds a per-combination output stability check (unstable flags).
module tt_sweep_ctrl #(
    parameter logic [7:0]  EXPECTED      = 8'h9A,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] mismatch,
    output logic [7:0] unstable
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       in_q, in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       captured_q, captured_d;
    logic [7:0]       mismatch_q, mismatch_d;
    logic [2:0]       idx;
`ifdef TT_SWEEP_STABILITY_EN
    logic             stab_q, stab_d;
    logic [7:0]       unstable_q, unstable_d;
`endif

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        idx        = 3'd7 - k_q;
`ifdef TT_SWEEP_STABILITY_EN
        stab_d     = stab_q;
        unstable_d = unstable_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    k_d        = 3'd0;
                    cnt_d      = '0;
                    captured_d = 8'h00;
                    mismatch_d = 8'h00;
                    pass_d     = 1'b0;
`ifdef TT_SWEEP_STABILITY_EN
                    unstable_d = 8'h00;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
`ifdef TT_SWEEP_STABILITY_EN
                    stab_d  = dut_out;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                captured_d[idx] = dut_out;
`ifdef TT_SWEEP_STABILITY_EN
                unstable_d[idx] = unstable_q[idx] | (dut_out != stab_q);
`endif
                if (k_q == 3'd7) begin
                    // Verdict is registered on entry to DONE so it is valid alongside the done pulse.
                    state_d    = DONE;
                    mismatch_d = captured_d ^ EXPECTED;
`ifdef TT_SWEEP_STABILITY_EN
                    pass_d     = (mismatch_d == 8'h00) && (unstable_d == 8'h00);
`else
                    pass_d     = (mismatch_d == 8'h00);
`endif
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        in_d   = busy_d ? k_d : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            cnt_q      <= '0;
            in_q       <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 8'h00;
            mismatch_q <= 8'h00;
`ifdef TT_SWEEP_STABILITY_EN
            stab_q     <= 1'b0;
            unstable_q <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            mismatch_q <= mismatch_d;
`ifdef TT_SWEEP_STABILITY_EN
            stab_q     <= stab_d;
            unstable_q <= unstable_d;
`endif
        end
    end

    assign in1      = in_q[2];
    assign in2      = in_q[1];
    assign in3      = in_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
    assign mismatch = mismatch_q;
`ifdef TT_SWEEP_STABILITY_EN
    assign unstable = unstable_q;
`else
    assign unstable = 8'h00;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (settle 4 and settle 1) driving behavioural gate models.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v;
    logic [1:0] dout_v;
    logic [1:0] in1_v, in2_v, in3_v, busy_v, done_v, pass_v;
    logic [7:0] cap_v [2];
    logic [7:0] mis_v [2];
    logic [7:0] uns_v [2];
    logic [2:0] cin   [2];
    logic [2:0] h1    [2];
    logic [2:0] h2    [2];

    int         errors  = 0;
    int         checks  = 0;
    int         cyc_abs = 0;
    logic [7:0] code_g  = 8'h9A;
    int         lag_g   = 0;
    bit         tog_g   = 1'b0;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.EXPECTED(8'h9A), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .dut_out(dout_v[0]),
        .in1(in1_v[0]), .in2(in2_v[0]), .in3(in3_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .captured(cap_v[0]), .mismatch(mis_v[0]), .unstable(uns_v[0])
    );

    tt_sweep_ctrl #(.EXPECTED(8'h9A), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .dut_out(dout_v[1]),
        .in1(in1_v[1]), .in2(in2_v[1]), .in3(in3_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .captured(cap_v[1]), .mismatch(mis_v[1]), .unstable(uns_v[1])
    );

    assign cin[0] = {in1_v[0], in2_v[0], in3_v[0]};
    assign cin[1] = {in1_v[1], in2_v[1], in3_v[1]};

    always @(posedge clk) begin
        cyc_abs <= cyc_abs + 1;
        h1[0]   <= cin[0];
        h2[0]   <= h1[0];
        h1[1]   <= cin[1];
        h2[1]   <= h1[1];
    end

    // Gate models: truth table code_g, optional 2-cycle lag, optional toggling output on combination 3.
    always_comb begin
        dout_v[0] = (tog_g && cin[0] == 3'd3) ? cyc_abs[0]
                  : code_g[3'd7 - ((lag_g == 2) ? h2[0] : cin[0])];
        dout_v[1] = (tog_g && cin[1] == 3'd3) ? cyc_abs[1 - 1]
                  : code_g[3'd7 - ((lag_g == 2) ? h2[1] : cin[1])];
    end

    // Combination driven in cycle c of a sweep (cycle 0 = start accepted).
    function automatic int m_in(int s, int c);
        if (c >= 1 && c <= 8 * (s + 1)) return (c - 1) / (s + 1);
        return 0;
    endfunction

    // Gate output seen during cycle c of a sweep that started at absolute cycle t0.
    function automatic bit m_out(int s, int c, int t0);
        int cur;
        int src;
        cur = m_in(s, c);
        src = m_in(s, c - lag_g);
        if (tog_g && cur == 3) return bit'((t0 + c) % 2);
        return code_g[7 - src];
    endfunction

    task automatic run_sweep(input int d, input int mode, input int rst_at);
        int         s;
        int         len;
        int         t0;
        int         smp;
        bit         aborted;
        logic       eb, ed;
        logic [2:0] ein, gin;
        logic [7:0] ecap, euns, emis;
        logic       epass;
        s   = (d == 0) ? 4 : 1;
        len = 8 * (s + 1);
        @(negedge clk);
        start_v[d] = 1'b1;
        t0 = cyc_abs;
        for (int k = 0; k < 8; k++) begin
            smp = (k + 1) * (s + 1);
            ecap[7 - k] = m_out(s, smp, t0);
`ifdef TT_SWEEP_STABILITY_EN
            euns[7 - k] = (m_out(s, smp - 1, t0) != m_out(s, smp, t0));
`else
            euns[7 - k] = 1'b0;
`endif
        end
        emis  = ecap ^ 8'h9A;
        epass = (emis == 8'h00) && (euns == 8'h00);
        for (int c = 1; c <= len + 8; c++) begin
            @(negedge clk);
            if (c == 1) start_v[d] = 1'b0;
            if (mode == 1 && c == 10) start_v[d] = 1'b1;
            if (c == len + 2) start_v[d] = 1'b0;
            aborted = (rst_at > 0) && (c > rst_at);
            eb  = !aborted && (c <= len);
            ed  = !aborted && (c == len + 1);
            ein = aborted ? 3'd0 : 3'(m_in(s, c));
            gin = cin[d];
            checks += 3;
            if (busy_v[d] !== eb) begin
                errors++;
                $display("FAIL busy d%0d cyc%0d: got %b want %b", d, c, busy_v[d], eb);
            end
            if (done_v[d] !== ed) begin
                errors++;
                $display("FAIL done d%0d cyc%0d: got %b want %b", d, c, done_v[d], ed);
            end
            if (gin !== ein) begin
                errors++;
                $display("FAIL inputs d%0d cyc%0d: got %0d want %0d", d, c, gin, ein);
            end
            if (!aborted && (c == len + 1 || c == len + 6)) begin
                checks += 4;
                if (cap_v[d] !== ecap) begin
                    errors++;
                    $display("FAIL captured d%0d cyc%0d: got %h want %h", d, c, cap_v[d], ecap);
                end
                if (mis_v[d] !== emis) begin
                    errors++;
                    $display("FAIL mismatch d%0d cyc%0d: got %h want %h", d, c, mis_v[d], emis);
                end
                if (pass_v[d] !== epass) begin
                    errors++;
                    $display("FAIL pass d%0d cyc%0d: got %b want %b", d, c, pass_v[d], epass);
                end
                if (uns_v[d] !== euns) begin
                    errors++;
                    $display("FAIL unstable d%0d cyc%0d: got %h want %h", d, c, uns_v[d], euns);
                end
            end
            if (aborted && c == rst_at + 1) begin
                checks += 3;
                if (cap_v[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL rst_captured d%0d: got %h want 00", d, cap_v[d]);
                end
                if (mis_v[d] !== 8'h00 || uns_v[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL rst_flags d%0d: got mis=%h uns=%h want 00", d, mis_v[d], uns_v[d]);
                end
                if (pass_v[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_pass d%0d: got %b want 0", d, pass_v[d]);
                end
            end
            if (rst_at > 0 && c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks += 2;
            if ({busy_v[d], done_v[d], pass_v[d], cin[d]} !== 6'd0) begin
                errors++;
                $display("FAIL reset_ctl d%0d: got busy=%b done=%b pass=%b in=%0d want all 0",
                         d, busy_v[d], done_v[d], pass_v[d], cin[d]);
            end
            if ({cap_v[d], mis_v[d], uns_v[d]} !== 24'd0) begin
                errors++;
                $display("FAIL reset_data d%0d: got cap=%h mis=%h uns=%h want 0",
                         d, cap_v[d], mis_v[d], uns_v[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_ideal();
        code_g = 8'h9A; lag_g = 0; tog_g = 1'b0;
        run_sweep(0, 0, 0);
        run_sweep(1, 0, 0);
    endtask

    task automatic test_stuck1();
        code_g = 8'hFF; lag_g = 0; tog_g = 1'b0;
        run_sweep(0, 0, 0);
    endtask

    task automatic test_random_gates();
        for (int i = 0; i < 4; i++) begin
            code_g = 8'($urandom);
            lag_g  = 0;
            tog_g  = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(i % 2, 0, 0);
        end
    endtask

    task automatic test_lag();
        code_g = 8'h9A; lag_g = 2; tog_g = 1'b0;
        run_sweep(1, 0, 0);
        run_sweep(0, 0, 0);
        lag_g = 0;
    endtask

    task automatic test_restart_ignored();
        code_g = 8'h9A; lag_g = 0; tog_g = 1'b0;
        run_sweep(0, 1, 0);
    endtask

    task automatic test_reset_mid();
        code_g = 8'h9A; lag_g = 0; tog_g = 1'b0;
        run_sweep(0, 0, 15);
        run_sweep(0, 0, 0);
    endtask

    task automatic test_unstable();
        code_g = 8'h9A; lag_g = 0; tog_g = 1'b1;
        run_sweep(0, 0, 0);
        tog_g = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck1();
        test_random_gates();
        test_lag();
        test_restart_ignored();
        test_reset_mid();
        test_unstable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
